// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory request at a time, computes the effective address,
// performs one data-memory access, and returns an extended load result or an error.
module load_store_unit #(
   parameter int unsigned WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [WORD_SIZE-1:0] req_base,
   input  logic [WORD_SIZE-1:0] req_offset,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WORD_SIZE-1:0] resp_rdata,
   output logic                 resp_err,
   output logic                 mem_write_en,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_write_data,
   output logic [2:0]           mem_ctrl,
   input  logic [WORD_SIZE-1:0] mem_data
);

   localparam int unsigned W = WORD_SIZE;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   addr_q, addr_d;
   logic [W-1:0]   wdata_q, wdata_d;
   logic [W-1:0]   rdata_q, rdata_d;
   logic [2:0]     funct3_q, funct3_d;
   logic           store_q, store_d;
   logic           we_q, we_d;
   logic           err_q, err_d;

   logic [W-1:0]   eff_addr;
   logic           req_err;
   logic [W-1:0]   ld_ext;

   // Address generation and request legality check
   always_comb begin
      eff_addr = req_base + req_offset;
      req_err  = 1'b0;
      if (req_we) begin
         if (!(req_funct3 inside {3'b000, 3'b001, 3'b010})) req_err = 1'b1;
      end else begin
         if (req_funct3 inside {3'b011, 3'b110, 3'b111}) req_err = 1'b1;
      end
      if (req_funct3[1:0] == 2'b01 && eff_addr[0]) req_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && eff_addr[1:0] != 2'b00) req_err = 1'b1;
   end

   // Load data extension selected by the latched access type
   always_comb begin
      case (funct3_q)
         3'b000:  ld_ext = {{(W-8){mem_data[7]}}, mem_data[7:0]};
         3'b100:  ld_ext = {{(W-8){1'b0}}, mem_data[7:0]};
         3'b001:  ld_ext = {{(W-16){mem_data[15]}}, mem_data[15:0]};
         3'b101:  ld_ext = {{(W-16){1'b0}}, mem_data[15:0]};
         default: ld_ext = mem_data;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         funct3_q <= 3'b000;
         store_q  <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         funct3_q <= funct3_d;
         store_q  <= store_d;
         we_q     <= we_d;
         err_q    <= err_d;
      end
   end

   // Next state; memory-side registers only load on a legal accept so they hold otherwise
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      funct3_d = funct3_q;
      store_d  = store_q;
      we_d     = 1'b0;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d  = ACCESS;
                  addr_d   = eff_addr;
                  wdata_d  = req_wdata;
                  funct3_d = req_funct3;
                  store_d  = req_we;
                  we_d     = req_we;
                  err_d    = 1'b0;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
            rdata_d = store_q ? '0 : ld_ext;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready      = (state_q == IDLE);
   assign resp_valid     = (state_q == RESP);
   assign resp_rdata     = rdata_q;
   assign resp_err       = err_q;
   assign mem_write_en   = we_q;
   assign mem_addr       = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_ctrl       = {1'b0, funct3_q[1:0]};

endmodule
